core_dmem_responder: RTL and testbench

//  Memory-side responder for the core data-memory port (req/grnt/addr/wdata/valid/ren/wen).

---
 rtl/core_dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_core_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_responder.sv
// Purpose : memory-side responder for the core data port; owns a word SRAM window.
// Latency : request accepted in cycle T -> rvalid_o in cycle T+LATENCY+1; one request in flight.
// Backpr. : grnt_o only in IDLE, so a held request waits for the previous response to finish.
//
// Ports:
//   clk_i, rst_i           clock (rising edge) and synchronous active-high reset
//   data_mem_req_i/grnt_o  request / combinational grant (accepted when both high)
//   data_mem_addr_i        byte address, decoded against [BASE_ADDR, BASE_ADDR+4*DEPTH)
//   data_mem_wdata_i       write data, qualified by data_mem_valid_i
//   data_mem_ren_i/wen_i   read / write select (exactly one must be set)
//   data_mem_rdata_o       read data, meaningful while data_mem_rvalid_o is high
//   data_mem_rvalid_o      single-cycle response strobe per granted request
//   data_mem_err_o         error flag, meaningful while data_mem_rvalid_o is high
module core_dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_mem_req_i,
    output logic        data_mem_grnt_o,
    input  logic [31:0] data_mem_addr_i,
    input  logic [31:0] data_mem_wdata_i,
    input  logic        data_mem_valid_i,
    input  logic        data_mem_ren_i,
    input  logic        data_mem_wen_i,
    output logic [31:0] data_mem_rdata_o,
    output logic        data_mem_rvalid_o,
    output logic        data_mem_err_o
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]      offset;
    logic             hit;
    logic [IDX_W-1:0] index;
    logic             req_err;
    logic             accept;
    logic             exec;
    logic             do_write;

    // Grant is held low during reset so nothing is accepted before the FSM is known-good.
    assign data_mem_grnt_o   = data_mem_req_i && (state_q == ST_IDLE) && !rst_i;
    assign accept            = data_mem_grnt_o;
    assign data_mem_rvalid_o = (state_q == ST_RESP);
    assign data_mem_rdata_o  = rdata_q;
    assign data_mem_err_o    = err_q;

    // Decode works on the latched address only. The unsigned subtraction wraps
    // addresses below BASE_ADDR to large offsets, so one compare covers both bounds.
    always_comb begin
        offset  = addr_q - BASE_ADDR;
        hit     = (offset < SPAN);
        index   = IDX_W'(offset >> 2);
        req_err = !hit
                || (addr_q[1:0] != 2'b00)
                || (ren_q && wen_q)
                || (!ren_q && !wen_q)
                || (wen_q && !valid_q);
    end

    // The access itself happens on the WAIT->RESP edge.
    assign exec     = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign do_write = exec && !rst_i && !req_err && wen_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = data_mem_addr_i;
                    wdata_d = data_mem_wdata_i;
                    valid_d = data_mem_valid_i;
                    ren_d   = data_mem_ren_i;
                    wen_d   = data_mem_wen_i;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    err_d   = req_err;
                    // Writes and errored requests return zero data.
                    rdata_d = (!req_err && ren_q) ? mem[index] : 32'h0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            valid_q <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_core_dmem_responder.sv
// Purpose : directed bench for core_dmem_responder, one instance at LATENCY=1 and one at LATENCY=3.
// Latency : response cycle is checked against the accept cycle for every transaction.
// Backpr. : grant is checked low while the responder is busy with a request held high.
module tb_core_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        grnt  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        valid [2];
    logic        ren   [2];
    logic        wen   [2];
    logic [31:0] rdata [2];
    logic        rvalid[2];
    logic        err   [2];

    int   total;
    int   bad;
    int   cyc;
    exp_t q0[$];
    exp_t q1[$];

    core_dmem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0001_0000), .INIT_FILE("")) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .data_mem_req_i(req[0]), .data_mem_grnt_o(grnt[0]),
        .data_mem_addr_i(addr[0]), .data_mem_wdata_i(wdata[0]),
        .data_mem_valid_i(valid[0]), .data_mem_ren_i(ren[0]), .data_mem_wen_i(wen[0]),
        .data_mem_rdata_o(rdata[0]), .data_mem_rvalid_o(rvalid[0]), .data_mem_err_o(err[0])
    );

    core_dmem_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0001_0000), .INIT_FILE("")) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .data_mem_req_i(req[1]), .data_mem_grnt_o(grnt[1]),
        .data_mem_addr_i(addr[1]), .data_mem_wdata_i(wdata[1]),
        .data_mem_valid_i(valid[1]), .data_mem_ren_i(ren[1]), .data_mem_wen_i(wen[1]),
        .data_mem_rdata_o(rdata[1]), .data_mem_rvalid_o(rvalid[1]), .data_mem_err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic push(input int s, input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        x.cyc   = c;
        if (s == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Response monitor: every rvalid pops one expectation for that instance.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rvalid[s] === 1'b1) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                if (s == 0 && q0.size() > 0) begin
                    e = q0.pop_front(); have = 1'b1;
                end else if (s == 1 && q1.size() > 0) begin
                    e = q1.pop_front(); have = 1'b1;
                end
                total++;
                assert (have) else begin
                    bad++;
                    $error("FAIL unexpected_rvalid dut%0d: observed rvalid=1 at cycle %0d, expected none", s, cyc);
                end
                if (have) begin
                    total++;
                    assert (rdata[s] === e.rdata) else begin
                        bad++;
                        $error("FAIL rdata dut%0d: observed %h expected %h", s, rdata[s], e.rdata);
                    end
                    total++;
                    assert (err[s] === e.err) else begin
                        bad++;
                        $error("FAIL err dut%0d: observed %b expected %b", s, err[s], e.err);
                    end
                    total++;
                    assert (cyc === e.cyc) else begin
                        bad++;
                        $error("FAIL rvalid_cycle dut%0d: observed %0d expected %0d", s, cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Drive one request, wait (bounded) for its grant, queue the expected response,
    // then scramble the inputs so any late sampling by the DUT shows up.
    task automatic issue(input int s, input logic [31:0] a, input logic [31:0] wd,
                         input logic v, input logic r, input logic w,
                         input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        req[s] = 1'b1; addr[s] = a; wdata[s] = wd; valid[s] = v; ren[s] = r; wen[s] = w;
        #1;
        n = 0;
        while (grnt[s] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        assert (grnt[s] === 1'b1) else begin
            bad++;
            $error("FAIL grant_timeout dut%0d: observed grnt=%b expected 1", s, grnt[s]);
        end
        if (grnt[s] === 1'b1) push(s, er, ee, cyc + lat_of(s) + 1);
        @(negedge clk);
        req[s]   = 1'b0;
        addr[s]  = $urandom;
        wdata[s] = $urandom;
        valid[s] = 1'($urandom);
        ren[s]   = 1'($urandom);
        wen[s]   = 1'($urandom);
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (((s == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        assert (((s == 0) ? q0.size() : q1.size()) === 0) else begin
            bad++;
            $error("FAIL drain_timeout dut%0d: observed %0d pending, expected 0", s, (s == 0) ? q0.size() : q1.size());
        end
    endtask

    initial begin
        int t0;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; addr[s] = 32'h0; wdata[s] = 32'h0;
            valid[s] = 1'b0; ren[s] = 1'b0; wen[s] = 1'b0;
        end
        req[0] = 1'b1;

        // Reset state.
        @(negedge clk);
        #1;
        total++;
        assert (grnt[0] === 1'b0) else begin bad++; $error("FAIL reset_grnt: observed %b expected 0", grnt[0]); end
        for (int s = 0; s < 2; s++) begin
            total++;
            assert (rvalid[s] === 1'b0) else begin bad++; $error("FAIL reset_rvalid dut%0d: observed %b expected 0", s, rvalid[s]); end
            total++;
            assert (err[s] === 1'b0) else begin bad++; $error("FAIL reset_err dut%0d: observed %b expected 0", s, err[s]); end
            total++;
            assert (rdata[s] === 32'h0) else begin bad++; $error("FAIL reset_rdata dut%0d: observed %h expected 0", s, rdata[s]); end
        end
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        req[0] = 1'b0;

        // LATENCY=1: write then read back, plus boundary and error cases.
        issue(0, 32'h0001_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0);
        issue(0, 32'h0001_0010, 32'h0,         1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        issue(0, 32'h0001_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0);
        issue(0, 32'h0001_0FFC, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0);
        issue(0, 32'h0001_0FFC, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE, 1'b0);
        issue(0, 32'h0000_FFFC, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1);
        issue(0, 32'h0001_0002, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b1);
        issue(0, 32'h0000_FFFC, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1);
        issue(0, 32'h0001_1000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1);
        issue(0, 32'h0001_0000, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 32'h0,         1'b1);
        issue(0, 32'h0001_0000, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 32'h0,         1'b1);
        issue(0, 32'h0001_0000, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1);
        issue(0, 32'h0001_0012, 32'h4444_4444, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1);
        issue(0, 32'h0001_0000, 32'h0,         1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
        issue(0, 32'h0001_0FFC, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0BAD_CAFE, 1'b0);
        issue(0, 32'h0001_0010, 32'h0,         1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        drain(0);

        // LATENCY=3: preload two words.
        issue(1, 32'h0001_0010, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        issue(1, 32'h0001_0014, 32'h5A5A_0001, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        drain(1);

        // Request held high for two reads; address changes while busy.
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 32'h0001_0010; wdata[1] = 32'h0;
        valid[1] = 1'b0; ren[1] = 1'b1; wen[1] = 1'b0;
        #1;
        t0 = cyc;
        total++;
        assert (grnt[1] === 1'b1) else begin bad++; $error("FAIL held_grnt_first: observed %b expected 1", grnt[1]); end
        push(1, 32'hA5A5_A5A5, 1'b0, t0 + 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr[1]  = 32'h0001_0014;
                wdata[1] = 32'hFFFF_FFFF;
            end
            #1;
            total++;
            assert (grnt[1] === 1'b0) else begin bad++; $error("FAIL held_grnt_busy k=%0d: observed %b expected 0", k, grnt[1]); end
        end
        @(negedge clk);
        #1;
        total++;
        assert (grnt[1] === 1'b1) else begin bad++; $error("FAIL held_grnt_second: observed %b expected 1", grnt[1]); end
        total++;
        assert (cyc === t0 + 5) else begin bad++; $error("FAIL held_grnt_cycle: observed %0d expected %0d", cyc, t0 + 5); end
        push(1, 32'h5A5A_0001, 1'b0, t0 + 9);
        @(negedge clk);
        req[1] = 1'b0;
        drain(1);

        // Reset in the last WAIT cycle of a write: no response, no commit.
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 32'h0001_0010; wdata[1] = 32'h1234_5678;
        valid[1] = 1'b1; ren[1] = 1'b0; wen[1] = 1'b1;
        #1;
        total++;
        assert (grnt[1] === 1'b1) else begin bad++; $error("FAIL rst_mid_grnt: observed %b expected 1", grnt[1]); end
        repeat (3) @(negedge clk);
        req[1] = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        #1;
        total++;
        assert (rvalid[1] === 1'b0) else begin bad++; $error("FAIL rst_mid_rvalid: observed %b expected 0", rvalid[1]); end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(1, 32'h0001_0010, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0);
        issue(1, 32'h0001_0014, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5A5A_0001, 1'b0);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
